// File: rtl/udma_ch_addrgen_2d.sv
// Linear/2D beat address generator for one uDMA channel with a one-deep queued descriptor and continuous reload.
// Latency: outputs are registered, so they reflect cfg_en_i/beat_i one cycle later. event_o pulses the cycle after the final beat.
// Backpressure: the core paces transfers through beat_i, one beat per cycle, with no bubble on reload. UDMA_ADDRGEN_2D_EN enables strided 2D mode.
module udma_ch_addrgen_2d #(
  parameter int AWIDTH     = 21,
  parameter int TRANS_SIZE = 20
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [AWIDTH-1:0]     cfg_startaddr_i,
  input  logic [TRANS_SIZE-1:0] cfg_size_i,
  input  logic [1:0]            cfg_datasize_i,
  input  logic                  cfg_continuous_i,
  input  logic                  cfg_en_i,
  input  logic                  cfg_clr_i,
`ifdef UDMA_ADDRGEN_2D_EN
  input  logic [TRANS_SIZE-1:0] cfg_2d_len_i,
  input  logic [TRANS_SIZE-1:0] cfg_2d_stride_i,
`endif
  input  logic                  beat_i,
  output logic [AWIDTH-1:0]     addr_o,
  output logic [1:0]            datasize_o,
  output logic [TRANS_SIZE-1:0] bytes_left_o,
  output logic                  busy_o,
  output logic                  pending_o,
  output logic                  event_o
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                r_state, w_state_nxt;
  logic [AWIDTH-1:0]     r_addr, w_addr_nxt;
  logic [TRANS_SIZE-1:0] r_left, w_left_nxt;
  logic [AWIDTH-1:0]     r_start, w_start_nxt;
  logic [TRANS_SIZE-1:0] r_size, w_size_nxt;
  logic [1:0]            r_dsize, w_dsize_nxt;
  logic                  r_cont, w_cont_nxt;
  logic [AWIDTH-1:0]     r_sh_start, w_sh_start_nxt;
  logic [TRANS_SIZE-1:0] r_sh_size, w_sh_size_nxt;
  logic [1:0]            r_sh_dsize, w_sh_dsize_nxt;
  logic                  r_sh_cont, w_sh_cont_nxt;
  logic                  r_pending, w_pending_nxt;
  logic                  r_event, w_event_nxt;

  // Descriptor load source selection (new cfg, shadow or reload of active)
  logic                  w_load;
  logic                  w_sh_cap;
  logic [AWIDTH-1:0]     w_ld_start;
  logic [TRANS_SIZE-1:0] w_ld_size;
  logic [1:0]            w_ld_dsize;
  logic                  w_ld_cont;

  logic [2:0]            w_bytes;
  logic [AWIDTH-1:0]     w_bytes_a;
  logic [TRANS_SIZE-1:0] w_bytes_t;
  logic                  w_final;
  logic                  w_en_ok;

`ifdef UDMA_ADDRGEN_2D_EN
  logic [TRANS_SIZE-1:0] r_len, w_len_nxt, r_stride, w_stride_nxt;
  logic [TRANS_SIZE-1:0] r_sh_len, w_sh_len_nxt, r_sh_stride, w_sh_stride_nxt;
  logic [TRANS_SIZE-1:0] r_row_cnt, w_row_cnt_nxt, w_row_sum;
  logic [AWIDTH-1:0]     r_row_start, w_row_start_nxt;
  logic [TRANS_SIZE-1:0] w_ld_len, w_ld_stride;
`endif

  assign w_bytes   = (r_dsize == 2'b00) ? 3'd1 : (r_dsize == 2'b01) ? 3'd2 : 3'd4;
  assign w_bytes_a = AWIDTH'(w_bytes);
  assign w_bytes_t = TRANS_SIZE'(w_bytes);
  // Final beat also covers a short tail when size is not a multiple of the beat
  assign w_final   = (r_left <= w_bytes_t);
  assign w_en_ok   = cfg_en_i && (cfg_size_i != '0);

  // State register and all datapath registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;  r_addr <= '0;     r_left <= '0;
      r_start <= '0;       r_size <= '0;     r_dsize <= '0;    r_cont <= 1'b0;
      r_sh_start <= '0;    r_sh_size <= '0;  r_sh_dsize <= '0; r_sh_cont <= 1'b0;
      r_pending <= 1'b0;   r_event <= 1'b0;
`ifdef UDMA_ADDRGEN_2D_EN
      r_len <= '0; r_stride <= '0; r_sh_len <= '0; r_sh_stride <= '0;
      r_row_cnt <= '0; r_row_start <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;  r_addr <= w_addr_nxt;       r_left <= w_left_nxt;
      r_start <= w_start_nxt;  r_size <= w_size_nxt;       r_dsize <= w_dsize_nxt;   r_cont <= w_cont_nxt;
      r_sh_start <= w_sh_start_nxt; r_sh_size <= w_sh_size_nxt;
      r_sh_dsize <= w_sh_dsize_nxt; r_sh_cont <= w_sh_cont_nxt;
      r_pending <= w_pending_nxt;   r_event <= w_event_nxt;
`ifdef UDMA_ADDRGEN_2D_EN
      r_len <= w_len_nxt; r_stride <= w_stride_nxt;
      r_sh_len <= w_sh_len_nxt; r_sh_stride <= w_sh_stride_nxt;
      r_row_cnt <= w_row_cnt_nxt; r_row_start <= w_row_start_nxt;
`endif
    end
  end

  // Next-state and datapath: clear beats everything, then launch/beat/queue handling
  always_comb begin
    w_state_nxt = r_state;  w_addr_nxt = r_addr;  w_left_nxt = r_left;
    w_start_nxt = r_start;  w_size_nxt = r_size;  w_dsize_nxt = r_dsize;  w_cont_nxt = r_cont;
    w_sh_start_nxt = r_sh_start; w_sh_size_nxt = r_sh_size;
    w_sh_dsize_nxt = r_sh_dsize; w_sh_cont_nxt = r_sh_cont;
    w_pending_nxt = r_pending;   w_event_nxt = 1'b0;
    w_load = 1'b0;  w_sh_cap = 1'b0;
    w_ld_start = cfg_startaddr_i;  w_ld_size = cfg_size_i;
    w_ld_dsize = cfg_datasize_i;   w_ld_cont = cfg_continuous_i;
`ifdef UDMA_ADDRGEN_2D_EN
    w_len_nxt = r_len; w_stride_nxt = r_stride;
    w_sh_len_nxt = r_sh_len; w_sh_stride_nxt = r_sh_stride;
    w_row_cnt_nxt = r_row_cnt; w_row_start_nxt = r_row_start;
    w_row_sum = r_row_cnt + w_bytes_t;
    w_ld_len = cfg_2d_len_i; w_ld_stride = cfg_2d_stride_i;
`endif

    if (cfg_clr_i) begin
      w_state_nxt   = ST_IDLE;
      w_pending_nxt = 1'b0;
      w_left_nxt    = '0;
    end else if (r_state == ST_IDLE) begin
      if (w_en_ok) begin
        w_load      = 1'b1;
        w_state_nxt = ST_RUN;
      end
    end else if (beat_i && w_final) begin
      w_event_nxt = 1'b1;
      if (r_pending) begin
        w_load = 1'b1;  w_pending_nxt = 1'b0;  w_sh_cap = w_en_ok;
        w_ld_start = r_sh_start; w_ld_size = r_sh_size;
        w_ld_dsize = r_sh_dsize; w_ld_cont = r_sh_cont;
`ifdef UDMA_ADDRGEN_2D_EN
        w_ld_len = r_sh_len; w_ld_stride = r_sh_stride;
`endif
      end else if (w_en_ok) begin
        // Queue bypass: the new descriptor wins over a continuous reload
        w_load = 1'b1;
      end else if (r_cont) begin
        w_load = 1'b1;
        w_ld_start = r_start; w_ld_size = r_size;
        w_ld_dsize = r_dsize; w_ld_cont = r_cont;
`ifdef UDMA_ADDRGEN_2D_EN
        w_ld_len = r_len; w_ld_stride = r_stride;
`endif
      end else begin
        w_state_nxt = ST_IDLE;
        w_addr_nxt  = r_addr + w_bytes_a;
        w_left_nxt  = '0;
      end
    end else begin
      w_sh_cap = w_en_ok;
      if (beat_i) begin
        w_left_nxt = r_left - w_bytes_t;
        w_addr_nxt = r_addr + w_bytes_a;
`ifdef UDMA_ADDRGEN_2D_EN
        // Row complete: jump to the next row start instead of the linear successor
        if (r_len != '0) begin
          if (w_row_sum >= r_len) begin
            w_row_start_nxt = r_row_start + AWIDTH'(r_stride);
            w_addr_nxt      = r_row_start + AWIDTH'(r_stride);
            w_row_cnt_nxt   = '0;
          end else begin
            w_row_cnt_nxt   = w_row_sum;
          end
        end
`endif
      end
    end

    if (w_load) begin
      w_start_nxt = w_ld_start; w_size_nxt = w_ld_size;
      w_dsize_nxt = w_ld_dsize; w_cont_nxt = w_ld_cont;
      w_addr_nxt  = w_ld_start; w_left_nxt = w_ld_size;
`ifdef UDMA_ADDRGEN_2D_EN
      w_len_nxt = w_ld_len; w_stride_nxt = w_ld_stride;
      w_row_start_nxt = w_ld_start; w_row_cnt_nxt = '0;
`endif
    end

    if (w_sh_cap) begin
      w_pending_nxt  = 1'b1;
      w_sh_start_nxt = cfg_startaddr_i; w_sh_size_nxt = cfg_size_i;
      w_sh_dsize_nxt = cfg_datasize_i;  w_sh_cont_nxt = cfg_continuous_i;
`ifdef UDMA_ADDRGEN_2D_EN
      w_sh_len_nxt = cfg_2d_len_i; w_sh_stride_nxt = cfg_2d_stride_i;
`endif
    end
  end

  assign addr_o       = r_addr;
  assign datasize_o   = r_dsize;
  assign bytes_left_o = r_left;
  assign busy_o       = (r_state == ST_RUN);
  assign pending_o    = r_pending;
  assign event_o      = r_event;

endmodule

// File: tb/tb_udma_ch_addrgen_2d.sv
// Directed testbench for udma_ch_addrgen_2d.
// Inputs are driven 1 time unit after each rising edge and outputs sampled at the same point.
// Covers linear, odd size, queue, bypass, continuous/clear, wrap, size-0, async reset and 2D.
module tb_udma_ch_addrgen_2d;
  localparam int AW = 21;
  localparam int TS = 20;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic [AW-1:0] cfg_startaddr_i;
  logic [TS-1:0] cfg_size_i;
  logic [1:0]    cfg_datasize_i;
  logic          cfg_continuous_i, cfg_en_i, cfg_clr_i, beat_i;
  logic [TS-1:0] cfg_2d_len_i, cfg_2d_stride_i;
  logic [AW-1:0] addr_o;
  logic [1:0]    datasize_o;
  logic [TS-1:0] bytes_left_o;
  logic          busy_o, pending_o, event_o;

  int n_vec = 0;
  int n_err = 0;

  udma_ch_addrgen_2d #(.AWIDTH(AW), .TRANS_SIZE(TS)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .cfg_startaddr_i(cfg_startaddr_i), .cfg_size_i(cfg_size_i),
    .cfg_datasize_i(cfg_datasize_i), .cfg_continuous_i(cfg_continuous_i),
    .cfg_en_i(cfg_en_i), .cfg_clr_i(cfg_clr_i),
`ifdef UDMA_ADDRGEN_2D_EN
    .cfg_2d_len_i(cfg_2d_len_i), .cfg_2d_stride_i(cfg_2d_stride_i),
`endif
    .beat_i(beat_i), .addr_o(addr_o), .datasize_o(datasize_o),
    .bytes_left_o(bytes_left_o), .busy_o(busy_o), .pending_o(pending_o),
    .event_o(event_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, vectors=%0d required=finish", n_vec);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one single-cycle launch pulse with the given descriptor
  task automatic launch(input logic [AW-1:0] st, input logic [TS-1:0] sz,
                        input logic [1:0] ds, input logic cont);
    cfg_startaddr_i = st; cfg_size_i = sz; cfg_datasize_i = ds; cfg_continuous_i = cont;
    cfg_en_i = 1'b1;
    tick();
    cfg_en_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; cfg_startaddr_i = '0; cfg_size_i = '0; cfg_datasize_i = '0;
    cfg_continuous_i = 0; cfg_en_i = 0; cfg_clr_i = 0; beat_i = 0;
    cfg_2d_len_i = '0; cfg_2d_stride_i = '0;
    tick(); tick();
    n_vec++; if (addr_o !== '0) begin n_err++; $display("FAIL reset_addr: got %h want 0", addr_o); end
    n_vec++; if (datasize_o !== 2'd0) begin n_err++; $display("FAIL reset_ds: got %h want 0", datasize_o); end
    n_vec++; if (bytes_left_o !== '0) begin n_err++; $display("FAIL reset_left: got %h want 0", bytes_left_o); end
    n_vec++; if ({busy_o, pending_o, event_o} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {busy_o, pending_o, event_o}); end
    rstn_i = 1'b1;
    tick();
  endtask

  task automatic test_linear();
    launch(21'h100, 20'd8, 2'b10, 1'b0);
    n_vec++; if (addr_o !== 21'h100) begin n_err++; $display("FAIL lin_addr0: got %h want 100", addr_o); end
    n_vec++; if (bytes_left_o !== 20'd8) begin n_err++; $display("FAIL lin_left0: got %0d want 8", bytes_left_o); end
    n_vec++; if (busy_o !== 1'b1 || datasize_o !== 2'b10) begin n_err++; $display("FAIL lin_busy_ds: got %b/%b want 1/10", busy_o, datasize_o); end
    beat_i = 1'b1;
    tick();
    n_vec++; if (addr_o !== 21'h104 || bytes_left_o !== 20'd4) begin n_err++; $display("FAIL lin_beat1: got %h/%0d want 104/4", addr_o, bytes_left_o); end
    n_vec++; if (event_o !== 1'b0) begin n_err++; $display("FAIL lin_early_evt: got %b want 0", event_o); end
    tick();
    beat_i = 1'b0;
    n_vec++; if (event_o !== 1'b1 || busy_o !== 1'b0) begin n_err++; $display("FAIL lin_end: evt/busy got %b/%b want 1/0", event_o, busy_o); end
    n_vec++; if (bytes_left_o !== '0) begin n_err++; $display("FAIL lin_left_end: got %0d want 0", bytes_left_o); end
    tick();
    n_vec++; if (event_o !== 1'b0) begin n_err++; $display("FAIL lin_evt_pulse: got %b want 0", event_o); end
  endtask

  // Datasize 11 behaves as a 4-byte beat; size 5 gives a 1-byte tail beat
  task automatic test_odd_size();
    launch(21'h010, 20'd5, 2'b11, 1'b0);
    n_vec++; if (bytes_left_o !== 20'd5) begin n_err++; $display("FAIL odd_left0: got %0d want 5", bytes_left_o); end
    beat_i = 1'b1;
    tick();
    n_vec++; if (bytes_left_o !== 20'd1 || addr_o !== 21'h014) begin n_err++; $display("FAIL odd_beat1: got %0d/%h want 1/014", bytes_left_o, addr_o); end
    tick();
    beat_i = 1'b0;
    n_vec++; if (event_o !== 1'b1 || busy_o !== 1'b0) begin n_err++; $display("FAIL odd_end: evt/busy got %b/%b want 1/0", event_o, busy_o); end
    tick();
    n_vec++; if (event_o !== 1'b0) begin n_err++; $display("FAIL odd_single_evt: got %b want 0", event_o); end
  endtask

  task automatic test_queue();
    launch(21'h300, 20'd8, 2'b10, 1'b0);
    launch(21'h200, 20'd4, 2'b10, 1'b0);
    n_vec++; if (pending_o !== 1'b1 || addr_o !== 21'h300) begin n_err++; $display("FAIL q_pending: got %b/%h want 1/300", pending_o, addr_o); end
    beat_i = 1'b1;
    tick();
    n_vec++; if (addr_o !== 21'h304 || pending_o !== 1'b1) begin n_err++; $display("FAIL q_beat1: got %h/%b want 304/1", addr_o, pending_o); end
    tick();
    n_vec++; if (addr_o !== 21'h200 || busy_o !== 1'b1 || pending_o !== 1'b0) begin n_err++; $display("FAIL q_swap: addr/busy/pend got %h/%b/%b want 200/1/0", addr_o, busy_o, pending_o); end
    n_vec++; if (bytes_left_o !== 20'd4 || event_o !== 1'b1) begin n_err++; $display("FAIL q_swap_left_evt: got %0d/%b want 4/1", bytes_left_o, event_o); end
    tick();
    beat_i = 1'b0;
    n_vec++; if (event_o !== 1'b1 || busy_o !== 1'b0) begin n_err++; $display("FAIL q_end: evt/busy got %b/%b want 1/0", event_o, busy_o); end
    tick();
  endtask

  task automatic test_bypass();
    launch(21'h040, 20'd4, 2'b10, 1'b0);
    cfg_startaddr_i = 21'h080; cfg_size_i = 20'd4; cfg_en_i = 1'b1; beat_i = 1'b1;
    tick();
    cfg_en_i = 1'b0;
    n_vec++; if (addr_o !== 21'h080 || busy_o !== 1'b1 || pending_o !== 1'b0 || event_o !== 1'b1) begin n_err++; $display("FAIL bypass: addr/busy/pend/evt got %h/%b/%b/%b want 080/1/0/1", addr_o, busy_o, pending_o, event_o); end
    tick();
    beat_i = 1'b0;
    n_vec++; if (event_o !== 1'b1 || busy_o !== 1'b0) begin n_err++; $display("FAIL bypass_end: evt/busy got %b/%b want 1/0", event_o, busy_o); end
    tick();
  endtask

  task automatic test_continuous_clear();
    launch(21'h500, 20'd4, 2'b00, 1'b1);
    beat_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_vec++; if (addr_o !== 21'h500 + 21'(i) || bytes_left_o !== 20'(4 - i)) begin n_err++; $display("FAIL cont_beat%0d: got %h/%0d want %h/%0d", i, addr_o, bytes_left_o, 21'h500 + 21'(i), 4 - i); end
    end
    tick();
    n_vec++; if (addr_o !== 21'h500 || bytes_left_o !== 20'd4 || event_o !== 1'b1 || busy_o !== 1'b1) begin n_err++; $display("FAIL cont_reload: addr/left/evt/busy got %h/%0d/%b/%b want 500/4/1/1", addr_o, bytes_left_o, event_o, busy_o); end
    tick();
    // Clear together with a beat and a launch: the launch is dropped
    cfg_clr_i = 1'b1; cfg_en_i = 1'b1; cfg_startaddr_i = 21'h700; cfg_size_i = 20'd8;
    tick();
    cfg_clr_i = 1'b0; cfg_en_i = 1'b0; beat_i = 1'b0;
    n_vec++; if (busy_o !== 1'b0 || bytes_left_o !== '0 || event_o !== 1'b0 || pending_o !== 1'b0) begin n_err++; $display("FAIL clr: busy/left/evt/pend got %b/%0d/%b/%b want 0/0/0/0", busy_o, bytes_left_o, event_o, pending_o); end
    tick();
    n_vec++; if (event_o !== 1'b0 || busy_o !== 1'b0) begin n_err++; $display("FAIL clr_after: evt/busy got %b/%b want 0/0", event_o, busy_o); end
  endtask

  task automatic test_wrap();
    launch(21'h1FFFFE, 20'd4, 2'b01, 1'b0);
    n_vec++; if (addr_o !== 21'h1FFFFE) begin n_err++; $display("FAIL wrap_addr0: got %h want 1ffffe", addr_o); end
    beat_i = 1'b1;
    tick();
    beat_i = 1'b0;
    n_vec++; if (addr_o !== 21'h000000 || bytes_left_o !== 20'd2) begin n_err++; $display("FAIL wrap_addr1: got %h/%0d want 000000/2", addr_o, bytes_left_o); end
    beat_i = 1'b1;
    tick();
    beat_i = 1'b0;
    n_vec++; if (event_o !== 1'b1 || busy_o !== 1'b0) begin n_err++; $display("FAIL wrap_end: evt/busy got %b/%b want 1/0", event_o, busy_o); end
    tick();
  endtask

  task automatic test_size0_idle_beat();
    launch(21'h123, 20'd0, 2'b10, 1'b0);
    n_vec++; if (busy_o !== 1'b0 || event_o !== 1'b0) begin n_err++; $display("FAIL size0: busy/evt got %b/%b want 0/0", busy_o, event_o); end
    beat_i = 1'b1;
    tick();
    beat_i = 1'b0;
    n_vec++; if (addr_o !== 21'h000002 || busy_o !== 1'b0 || event_o !== 1'b0) begin n_err++; $display("FAIL idle_beat: addr/busy/evt got %h/%b/%b want 000002/0/0", addr_o, busy_o, event_o); end
  endtask

  task automatic test_async_reset();
    launch(21'h600, 20'd16, 2'b10, 1'b0);
    launch(21'h800, 20'd4, 2'b10, 1'b0);
    beat_i = 1'b1;
    tick();
    #2 rstn_i = 1'b0;
    #1;
    n_vec++; if (addr_o !== '0 || bytes_left_o !== '0 || datasize_o !== 2'd0 || {busy_o, pending_o, event_o} !== 3'b000) begin n_err++; $display("FAIL async_rst: addr/left/ds/flags got %h/%0d/%h/%b want 0/0/0/000", addr_o, bytes_left_o, datasize_o, {busy_o, pending_o, event_o}); end
    beat_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    tick();
    n_vec++; if (event_o !== 1'b0 || busy_o !== 1'b0) begin n_err++; $display("FAIL async_rst_after: evt/busy got %b/%b want 0/0", event_o, busy_o); end
  endtask

`ifdef UDMA_ADDRGEN_2D_EN
  task automatic test_2d();
    logic [AW-1:0] exp_a [4];
    exp_a[0] = 21'h0; exp_a[1] = 21'h4; exp_a[2] = 21'h40; exp_a[3] = 21'h44;
    cfg_2d_len_i = 20'd8; cfg_2d_stride_i = 20'h40;
    launch(21'h0, 20'd16, 2'b10, 1'b0);
    beat_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (addr_o !== exp_a[i]) begin n_err++; $display("FAIL 2d_addr%0d: got %h want %h", i, addr_o, exp_a[i]); end
      tick();
    end
    beat_i = 1'b0;
    n_vec++; if (event_o !== 1'b1 || busy_o !== 1'b0) begin n_err++; $display("FAIL 2d_end: evt/busy got %b/%b want 1/0", event_o, busy_o); end
    cfg_2d_len_i = '0; cfg_2d_stride_i = '0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_linear();
    test_odd_size();
    test_queue();
    test_bypass();
    test_continuous_clear();
    test_wrap();
    test_size0_idle_beat();
    test_async_reset();
`ifdef UDMA_ADDRGEN_2D_EN
    test_2d();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/udma_ch_addrgen_2d.md
# udma_ch_addrgen_2d

Parametrised linear/2D address generator for one uDMA channel, replacing fixed-width per-channel address counters. It sits between a channel's APB config registers and the uDMA core arbiter. It latches a transfer descriptor (start address, byte count, beat size), produces the L2 address for each beat, and counts down the remaining bytes. Over fixed-width counters it adds a one-deep queued descriptor, continuous mode and optional 2D strided addressing.

## Interface
- AWIDTH, 21, L2 byte-address width (L2 address bits + 2)
- TRANS_SIZE, 20, byte-count width
- clk_i  in  1  clock, all logic on rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- cfg_startaddr_i  in  AWIDTH  descriptor start byte address
- cfg_size_i  in  TRANS_SIZE  descriptor length in bytes
- cfg_datasize_i  in  2  beat size: 00 byte, 01 half, 10/11 word
- cfg_continuous_i  in  1  reload descriptor on completion
- cfg_en_i  in  1  single-cycle descriptor-launch pulse
- cfg_clr_i  in  1  single-cycle abort pulse
- cfg_2d_len_i  in  TRANS_SIZE  row length in bytes (macro only)
- cfg_2d_stride_i  in  TRANS_SIZE  row-start increment in bytes (macro only)
- beat_i  in  1  current beat accepted by core
- addr_o  out  AWIDTH  address of current beat
- datasize_o  out  2  latched beat size
- bytes_left_o  out  TRANS_SIZE  bytes remaining incl. current beat
- busy_o  out  1  descriptor active
- pending_o  out  1  queued descriptor held
- event_o  out  1  end-of-transfer pulse

## Operation
- States: IDLE, RUN. Beat bytes B = 1, 2 or 4 from latched datasize (11 treated as 4).
- Descriptor capture:
  - IDLE + cfg_en_i with cfg_size_i != 0: latch all cfg fields into the active registers; addr_o = start; bytes_left_o = size; go to RUN.
  - cfg_en_i with size 0: ignored, no event.
- Queueing:
  - RUN + cfg_en_i: fields go into the shadow registers and pending_o = 1.
  - A second cfg_en_i while pending overwrites the shadow.
- Beats: in RUN, each beat_i sets addr += B (modulo 2^AWIDTH) and bytes_left -= B, saturating at 0.
- A beat is final when bytes_left <= B, which covers sizes that are not a multiple of B. On the final beat:
  - If pending: load the shadow into the active registers, clear pending_o, stay in RUN.
  - Else if continuous: reload the latched start and size, stay in RUN.
  - Else: go to IDLE.
- Final beat + cfg_en_i in the same cycle with no pending descriptor: the new descriptor loads directly as active (queue bypass). In continuous mode this bypass takes priority over the reload.
- cfg_clr_i: go to IDLE, clear pending, zero bytes_left_o, suppress event_o. It has priority over cfg_en_i and beat_i in the same cycle; that cfg_en_i is dropped.
- beat_i in IDLE: ignored.

## Timing
- Reset values: addr_o = 0, datasize_o = 0, bytes_left_o = 0, busy_o = 0, pending_o = 0, event_o = 0. The state machine resets to IDLE.
- All outputs are registered. addr_o, bytes_left_o and busy_o are valid the cycle after cfg_en_i. Each beat_i updates the outputs the next cycle.
- event_o is a one-cycle pulse in the cycle after the final beat. It fires once per completed descriptor, including continuous reloads.
- Back-to-back beats are supported, one per cycle, with no bubble across queued-descriptor or continuous reloads.
- Reset asserted mid-transfer forces every output to its reset value immediately. No event is produced.

## Configuration
- UDMA_ADDRGEN_2D_EN defined:
  - Adds the cfg_2d_len_i and cfg_2d_stride_i ports and a row byte counter plus a row-start register.
  - At descriptor load, row_start = start. Each beat adds B to the row counter.
  - When the row counter reaches len: row_start += stride, addr = new row_start, row counter = 0.
  - len = 0 disables 2D addressing for that descriptor (linear mode).
  - The 2D fields are shadowed and queued like the other fields.
- UDMA_ADDRGEN_2D_EN undefined: the 2D ports, registers and logic are absent; behaviour is purely linear.

## Test plan
- Linear transfer: start = 0x100, size = 8, datasize = 10, beats on consecutive cycles -> addr_o 0x100 then 0x104, bytes_left_o 8 then 4, event_o one cycle after the 2nd beat, busy_o = 0.
- Odd size: size = 5, datasize = 10 -> 2 beats, bytes_left_o 5 then 1, single event_o.
- Queued descriptor: cfg_en_i (start = 0x200, size = 4) issued mid-RUN -> pending_o = 1; after the first descriptor's final beat, addr_o = 0x200 with no idle cycle and pending_o = 0.
- Continuous + clear: continuous, size = 4, datasize = 00 -> after 4 beats event_o pulses and addr_o returns to start; cfg_clr_i coinciding with a beat -> IDLE, no event, bytes_left_o = 0.
- Wrap: start = 0x1FFFFE, datasize = 01, size = 4 -> addr_o 0x1FFFFE then 0x000000.
- 2D (macro on): start = 0, len = 8, stride = 0x40, size = 16, datasize = 10 -> addr_o sequence 0x0, 0x4, 0x40, 0x44.
